// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, depth derivation and Gray encoding.
// Pure declarations, no logic; imported by both pointer handlers.
package fifo_pkg;

   localparam int ADDRESS_SIZE_DEFAULT       = 5;
   localparam int ALMOST_FULL_MARGIN_DEFAULT = 4;

   function automatic int depth_of(input int address_size);
      return 1 << address_size;
   endfunction

   function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter for a DATA_WIDTH+1 bit pointer (address plus lap bit).
// Zero latency; no flow control.
module gray_to_binary #(
   parameter int DATA_WIDTH = 5
) (
   input  logic [DATA_WIDTH:0] gray,
   output logic [DATA_WIDTH:0] binary
);

   // Each binary bit is the XOR of all Gray bits at or above its position.
   for (genvar i = 0; i <= DATA_WIDTH; i++) begin : g_bit
      assign binary[i] = ^gray[DATA_WIDTH:i];
   end

endmodule

// File: rtl/write_handler.sv
// Write-domain pointer/flag logic of the async FIFO: binary RAM address, Gray pointer, full/almost-full/level/overflow.
// Flags register one cycle after the causing edge; writes while full are dropped and latch a sticky overflow.
module write_handler
   import fifo_pkg::*;
#(
   parameter int ADDRESS_SIZE       = ADDRESS_SIZE_DEFAULT,
   parameter int ALMOST_FULL_MARGIN = ALMOST_FULL_MARGIN_DEFAULT
) (
   input  logic                    write_clock,
   input  logic                    reset,
   input  logic                    write_enable,
   input  logic                    clear_overflow,
   input  logic [ADDRESS_SIZE:0]   synch_rgpointer,
   output logic [ADDRESS_SIZE-1:0] write_address,
   output logic                    mem_write_enable,
   output logic [ADDRESS_SIZE:0]   write_pointer,
   output logic                    write_full,
   output logic                    write_almost_full,
   output logic [ADDRESS_SIZE:0]   write_level,
   output logic                    write_overflow
);

   localparam int PW    = ADDRESS_SIZE + 1;
   localparam int DEPTH = depth_of(ADDRESS_SIZE);

   localparam logic [PW-1:0] FULL_LEVEL   = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_LEVEL  = PW'(DEPTH - ALMOST_FULL_MARGIN);

   logic [PW-1:0] wbin_q,  wbin_d;
   logic [PW-1:0] wgray_q, wgray_d;
   logic [PW-1:0] level_q, level_d;
   logic          full_q,  full_d;
   logic          afull_q, afull_d;
   logic          ovf_q,   ovf_d;

   logic [PW-1:0] rbin;

   gray_to_binary #(
      .DATA_WIDTH (ADDRESS_SIZE)
   ) u_rptr_g2b (
      .gray   (synch_rgpointer),
      .binary (rbin)
   );

   // Blocking on the registered full flag is what keeps a write from ever slipping in while full.
   assign mem_write_enable = write_enable && !full_q;

   always_comb begin
      wbin_d  = wbin_q + {{ADDRESS_SIZE{1'b0}}, mem_write_enable};
      wgray_d = (wbin_d >> 1) ^ wbin_d;
      level_d = wbin_d - rbin;
      full_d  = (level_d == FULL_LEVEL);
      afull_d = (level_d >= AFULL_LEVEL);
      ovf_d   = ovf_q;
      if (write_enable && full_q) begin
         ovf_d = 1'b1;
      end else if (clear_overflow) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         level_q <= level_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   assign write_address     = wbin_q[ADDRESS_SIZE-1:0];
   assign write_pointer     = wgray_q;
   assign write_level       = level_q;
   assign write_full        = full_q;
   assign write_almost_full = afull_q;
   assign write_overflow    = ovf_q;

endmodule

// File: tb/tb_write_handler.sv
// Directed and randomized checks of write_handler against a count-based model of the write side.
module tb_write_handler;

   localparam int AW     = 5;
   localparam int DEPTH  = 32;
   localparam int MARGIN = 4;

   logic       write_clock = 1'b0;
   logic       reset;
   logic       write_enable;
   logic       clear_overflow;
   logic [5:0] synch_rgpointer;
   logic [4:0] write_address;
   logic       mem_write_enable;
   logic [5:0] write_pointer;
   logic       write_full;
   logic       write_almost_full;
   logic [5:0] write_level;
   logic       write_overflow;

   write_handler #(
      .ADDRESS_SIZE       (AW),
      .ALMOST_FULL_MARGIN (MARGIN)
   ) dut (
      .write_clock       (write_clock),
      .reset             (reset),
      .write_enable      (write_enable),
      .clear_overflow    (clear_overflow),
      .synch_rgpointer   (synch_rgpointer),
      .write_address     (write_address),
      .mem_write_enable  (mem_write_enable),
      .write_pointer     (write_pointer),
      .write_full        (write_full),
      .write_almost_full (write_almost_full),
      .write_level       (write_level),
      .write_overflow    (write_overflow)
   );

   always #5 write_clock = ~write_clock;

   int checks = 0;
   int passed = 0;

   // Model: total accepted writes and total reads, as plain unbounded counts.
   int wcount;
   int rcount;
   int m_level;
   bit m_full;
   bit m_af;
   bit m_ovf;

   function automatic logic [5:0] gray6(input int n);
      int b;
      b = n % 64;
      return 6'(b ^ (b >> 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      wcount  = 0;
      rcount  = 0;
      m_level = 0;
      m_full  = 1'b0;
      m_af    = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic check_state(input string ctx);
      chk({ctx, ".addr"},  32'(write_address),     32'(wcount % DEPTH));
      chk({ctx, ".gptr"},  32'(write_pointer),     32'(gray6(wcount)));
      chk({ctx, ".level"}, 32'(write_level),       32'(m_level));
      chk({ctx, ".full"},  32'(write_full),        32'(m_full));
      chk({ctx, ".afull"}, 32'(write_almost_full), 32'(m_af));
      chk({ctx, ".ovf"},   32'(write_overflow),    32'(m_ovf));
   endtask

   // Called at a falling edge: drive inputs, check the strobe, advance the model, check after the edge.
   task automatic cycle(input bit we, input bit clr, input int rc, input string ctx, output bit accepted);
      write_enable    = we;
      clear_overflow  = clr;
      rcount          = rc;
      synch_rgpointer = gray6(rc);
      #1;
      accepted = mem_write_enable;
      chk({ctx, ".mwe"}, 32'(mem_write_enable), 32'(we && !m_full));
      if (we && !m_full) wcount++;
      if (we && m_full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_level = wcount - rcount;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= DEPTH - MARGIN);
      @(negedge write_clock);
      check_state(ctx);
   endtask

   task automatic pulse_reset();
      write_enable = 1'b0;
      clear_overflow = 1'b0;
      synch_rgpointer = '0;
      reset = 1'b1;
      @(negedge write_clock);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bit acc;
      int pulses;
      int af_at;
      int full_at;
      int rc;
      int accepted_total;
      bit wrap_seen;
      bit full_seen;
      logic [5:0] prev_ptr;
      logic [4:0] prev_addr;

      // Reset state
      reset = 1'b1;
      write_enable = 1'b0;
      clear_overflow = 1'b0;
      synch_rgpointer = '0;
      model_reset();
      @(negedge write_clock);
      check_state("rst0");
      reset = 1'b0;

      // Asynchronous reset mid-stream at level 10
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 0, "pre", acc);
      chk("pre.level10", 32'(write_level), 32'd10);
      write_enable = 1'b1;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_state("arst");
      chk("arst.mwe_follows", 32'(mem_write_enable), 32'd1);
      @(negedge write_clock);
      reset = 1'b0;
      cycle(1'b1, 1'b0, 0, "post_rst", acc);
      chk("post_rst.addr1", 32'(write_address), 32'd1);
      chk("post_rst.gptr1", 32'(write_pointer), 32'b000001);

      // Fill with the reader stalled
      pulse_reset();
      pulses = 0;
      af_at = -1;
      full_at = -1;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 1'b0, 0, "fill", acc);
         if (acc) pulses++;
         if (write_almost_full && af_at < 0) af_at = pulses;
         if (write_full && full_at < 0) full_at = pulses;
      end
      chk("fill.pulses", 32'(pulses), 32'd32);
      chk("fill.afull_after", 32'(af_at), 32'd28);
      chk("fill.full_after", 32'(full_at), 32'd32);
      chk("fill.level", 32'(write_level), 32'd32);
      chk("fill.ovf", 32'(write_overflow), 32'd1);

      // Reader advance releases full without any write
      cycle(1'b0, 1'b0, 3, "release", acc);
      chk("release.full", 32'(write_full), 32'd0);
      chk("release.level", 32'(write_level), 32'd29);
      chk("release.afull", 32'(write_almost_full), 32'd1);

      // Overflow clear alone, then clear racing a blocked write
      cycle(1'b0, 1'b1, 3, "clr", acc);
      chk("clr.ovf", 32'(write_overflow), 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3, "refill", acc);
      chk("refill.full", 32'(write_full), 32'd1);
      cycle(1'b1, 1'b1, 3, "clr_race", acc);
      chk("clr_race.ovf", 32'(write_overflow), 32'd1);
      chk("clr_race.dropped", 32'(write_address), 32'd3);

      // Wrap streaming with the reader two entries behind
      cycle(1'b0, 1'b1, wcount - 2, "wrap0", acc);
      accepted_total = 0;
      wrap_seen = 1'b0;
      full_seen = 1'b0;
      prev_ptr = write_pointer;
      prev_addr = write_address;
      for (int i = 0; i < 200 && accepted_total < 100; i++) begin
         cycle(1'b1, 1'b0, (wcount >= 2) ? wcount - 2 : 0, "wrap", acc);
         if (acc) accepted_total++;
         if ($countones(write_pointer ^ prev_ptr) > 1) chk("wrap.gray_step", 32'($countones(write_pointer ^ prev_ptr)), 32'd1);
         if (prev_addr == 5'd31 && write_address == 5'd0) wrap_seen = 1'b1;
         if (write_full) full_seen = 1'b1;
         prev_ptr = write_pointer;
         prev_addr = write_address;
      end
      chk("wrap.count", 32'(accepted_total), 32'd100);
      chk("wrap.addr_wrapped", 32'(wrap_seen), 32'd1);
      chk("wrap.never_full", 32'(full_seen), 32'd0);

      // Randomized traffic with a slow, bursty reader
      pulse_reset();
      rc = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0 && rc < wcount) rc = rc + 1;
         if ($urandom_range(0, 15) == 0) rc = wcount;
         prev_ptr = write_pointer;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rc, "rand", acc);
         if ($countones(write_pointer ^ prev_ptr) > 1) chk("rand.gray_step", 32'($countones(write_pointer ^ prev_ptr)), 32'd1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
